// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt trap controller: FSM encoding, config
// register map and the machine-external interrupt mcause value.
package irq_ctrl_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] CFG_ENABLE   = 2'd0;
  localparam logic [1:0] CFG_PENDING  = 2'd1;
  localparam logic [1:0] CFG_EDGE_SEL = 2'd2;
  localparam logic [1:0] CFG_CLAIM    = 2'd3;

  localparam logic [31:0] IRQ_MCAUSE = 32'h8000000B;
endpackage

// File: rtl/irq_trap_controller_if.sv
// Bus between SoC/core side and the interrupt trap controller: raw sources,
// config register port and the exception-unit request/ack handshake.
interface irq_trap_controller_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
);
  logic [NUM_SRC-1:0] src_irq;
  logic               cfg_we;
  logic [1:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               mie;
  logic               trap_ack;
  logic               mret;
  logic               irq_out;
  logic [ID_W-1:0]    irq_id;
  logic               busy;

  modport master (
    output src_irq, cfg_we, cfg_addr, cfg_wdata, mie, trap_ack, mret,
    input  cfg_rdata, irq_out, irq_id, busy
  );

  modport slave (
    input  src_irq, cfg_we, cfg_addr, cfg_wdata, mie, trap_ack, mret,
    output cfg_rdata, irq_out, irq_id, busy
  );
endinterface

// File: rtl/irq_arbiter.sv
// Combinational winner pick over the eligible-request mask.
// IRQ_ROUND_ROBIN_EN: first request above i_last (wrapping); else lowest index.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] i_req,
`ifdef IRQ_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    i_last,
`endif
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);
`ifdef IRQ_ROUND_ROBIN_EN
  always_comb begin
    int idx;
    idx     = 0;
    o_valid = 1'b0;
    o_id    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(i_last) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!o_valid && i_req[idx]) begin
        o_valid = 1'b1;
        o_id    = ID_W'(idx);
      end
    end
  end
`else
  // Scan high to low so the lowest set index is the last write.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end
`endif
endmodule

// File: rtl/irq_trap_controller.sv
// Interrupt trap controller: sync, latch pending, mask, arbitrate, and walk each
// interrupt through request -> trap -> handler -> mret. Option: IRQ_ROUND_ROBIN_EN.
module irq_trap_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input logic                 clk,
  input logic                 rst,
  irq_trap_controller_if.slave bus
);
  logic [NUM_SRC-1:0] r_sync1, r_sync2, r_sync_d;
  logic [NUM_SRC-1:0] r_en, r_pend, r_edge;
  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_id;

  logic [NUM_SRC-1:0] w_wdata, w_rise, w_clr, w_ack_oh, w_pend_nxt;
  logic               w_ack, w_valid, w_busy, w_unused;
  logic [ID_W-1:0]    w_win;
  logic [31:0]        w_rdata;

  assign w_wdata  = bus.cfg_wdata[NUM_SRC-1:0];
  assign w_unused = ^bus.cfg_wdata;
  assign w_rise   = r_sync2 & ~r_sync_d;
  assign w_ack    = (r_state == ST_ASSERT) && bus.trap_ack;
  assign w_busy   = (r_state != ST_IDLE);

  always_comb begin
    w_ack_oh = '0;
    if (w_ack) w_ack_oh[r_id] = 1'b1;
  end

  // Edge bits: set beats clear. Level bits simply track the synced line.
  assign w_clr      = ((bus.cfg_we && bus.cfg_addr == CFG_PENDING) ? w_wdata : '0) | w_ack_oh;
  assign w_pend_nxt = (r_edge & ((r_pend & ~w_clr) | w_rise)) | (~r_edge & r_sync2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync_d <= '0;
      r_pend   <= '0;
    end else begin
      r_sync1  <= bus.src_irq;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_pend   <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en   <= '0;
      r_edge <= '0;
    end else if (bus.cfg_we) begin
      if (bus.cfg_addr == CFG_ENABLE)   r_en   <= w_wdata;
      if (bus.cfg_addr == CFG_EDGE_SEL) r_edge <= w_wdata;
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_last <= ID_W'(NUM_SRC - 1);
    else if (w_ack) r_last <= r_id;
  end

  irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arb (
    .i_req   (r_pend & r_en),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_id    (w_win)
  );
`else
  irq_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arb (
    .i_req   (r_pend & r_en),
    .o_valid (w_valid),
    .o_id    (w_win)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid && bus.mie) begin
            r_id    <= w_win;
            r_state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // Ack outranks any withdrawal seen in the same cycle.
          if (bus.trap_ack)                       r_state <= ST_SERVICE;
          else if (!r_pend[r_id] || !r_en[r_id])  r_state <= ST_IDLE;
          else if (!bus.mie)                      r_state <= ST_IDLE;
        end
        ST_SERVICE: begin
          if (bus.mret) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.cfg_addr)
      CFG_ENABLE:   w_rdata = 32'(r_en);
      CFG_PENDING:  w_rdata = 32'(r_pend);
      CFG_EDGE_SEL: w_rdata = 32'(r_edge);
      default:      w_rdata = 32'({w_busy, r_id});
    endcase
  end

  assign bus.cfg_rdata = w_rdata;
  assign bus.irq_out   = (r_state == ST_ASSERT);
  assign bus.irq_id    = r_id;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_irq_trap_controller.sv
// Scenario bench for irq_trap_controller: expected winner ids queued on stimulus,
// popped when irq_out rises.
module tb_irq_trap_controller;
  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_q[$];

  irq_trap_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

  irq_trap_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    tick(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic pulse_ack;
    bus.trap_ack = 1'b1; tick(1); bus.trap_ack = 1'b0;
  endtask

  task automatic pulse_mret;
    bus.mret = 1'b1; tick(1); bus.mret = 1'b0;
  endtask

  task automatic apply_reset;
    bus.src_irq = '0; bus.cfg_we = 1'b0; bus.trap_ack = 1'b0; bus.mret = 1'b0;
    rst = 1'b0;
    #3;
    @(negedge clk) rst = 1'b1;
    tick(1);
  endtask

  // Bounded wait for a request; the popped id is what the scenario queued.
  task automatic wait_irq(input string nm);
    int n;
    int exp_id;
    n = 0;
    exp_id = exp_q.pop_front();
    while (bus.irq_out !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    vectors++;
    if (bus.irq_out !== 1'b1) begin
      miscompares++;
      $display("FAIL %s irq_out timeout: got %b want 1", nm, bus.irq_out);
    end else if (bus.irq_id !== ID_W'(exp_id)) begin
      miscompares++;
      $display("FAIL %s irq_id: got %0d want %0d", nm, bus.irq_id, exp_id);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    bus.src_irq = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.mie = 1'b0; bus.trap_ack = 1'b0; bus.mret = 1'b0;
    #2 rst = 1'b0;
    #10;
    vectors++;
    if ({bus.irq_out, bus.irq_id, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got irq_out=%b id=%0d busy=%b want 0/0/0",
               bus.irq_out, bus.irq_id, bus.busy);
    end
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d got %h want 0", a, d);
      end
    end
    @(negedge clk) rst = 1'b1;
    tick(1);
  endtask

  task automatic test_edge;
    logic [31:0] d;
    apply_reset();
    cfg_write(2'd0, 32'h04);
    cfg_write(2'd2, 32'h04);
    bus.mie = 1'b1;
    tick(2);
    bus.src_irq[2] = 1'b1;
    exp_q.push_back(2);
    tick(1);
    bus.src_irq[2] = 1'b0;
    tick(2);
    cfg_read(2'd1, d);
    vectors++;
    if (d !== 32'h04 || bus.irq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_pending_n2 got pend=%h irq_out=%b want 04/0", d, bus.irq_out);
    end
    tick(1);
    vectors++;
    if (bus.irq_out !== 1'b1) begin
      miscompares++;
      $display("FAIL edge_latency_n3 got irq_out=%b want 1", bus.irq_out);
    end
    wait_irq("edge_id");
    pulse_ack();
    cfg_read(2'd1, d);
    vectors++;
    if (bus.irq_out !== 1'b0 || bus.busy !== 1'b1 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_after_ack got irq_out=%b busy=%b pend=%h want 0/1/0",
               bus.irq_out, bus.busy, d);
    end
    cfg_read(2'd3, d);
    vectors++;
    if (d !== 32'h0A) begin
      miscompares++;
      $display("FAIL edge_claim got %h want 0a", d);
    end
    pulse_mret();
    vectors++;
    if (bus.busy !== 1'b0 || bus.irq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL edge_after_mret got busy=%b irq_out=%b want 0/0", bus.busy, bus.irq_out);
    end
  endtask

  task automatic test_level_priority;
    apply_reset();
    cfg_write(2'd0, 32'h22);
    bus.mie = 1'b1;
    bus.src_irq[1] = 1'b1;
    bus.src_irq[5] = 1'b1;
    exp_q.push_back(1);
    wait_irq("level_first");
    pulse_ack();
    tick(1);
    pulse_mret();
`ifdef IRQ_ROUND_ROBIN_EN
    exp_q.push_back(5);
`else
    exp_q.push_back(1);
`endif
    wait_irq("level_second");
    pulse_ack();
    bus.src_irq[1] = 1'b0;
    tick(5);
    pulse_mret();
    exp_q.push_back(5);
    wait_irq("level_after_drop");
    pulse_ack();
    bus.src_irq[5] = 1'b0;
    tick(5);
    pulse_mret();
    tick(2);
    vectors++;
    if (bus.irq_out !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL level_quiet got irq_out=%b busy=%b want 0/0", bus.irq_out, bus.busy);
    end
  endtask

  task automatic test_enable_withdraw;
    apply_reset();
    cfg_write(2'd0, 32'h01);
    bus.mie = 1'b1;
    bus.src_irq[0] = 1'b1;
    exp_q.push_back(0);
    wait_irq("withdraw_req");
    cfg_write(2'd0, 32'h00);
    tick(1);
    vectors++;
    if (bus.irq_out !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_idle got irq_out=%b busy=%b want 0/0", bus.irq_out, bus.busy);
    end
    tick(3);
    vectors++;
    if (bus.irq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_stays got irq_out=%b want 0", bus.irq_out);
    end
    bus.src_irq[0] = 1'b0;
  endtask

  task automatic test_mie;
    logic [31:0] d;
    apply_reset();
    bus.mie = 1'b0;
    cfg_write(2'd0, 32'h01);
    bus.src_irq[0] = 1'b1;
    tick(6);
    cfg_read(2'd1, d);
    vectors++;
    if (bus.irq_out !== 1'b0 || d !== 32'h01) begin
      miscompares++;
      $display("FAIL mie_masked got irq_out=%b pend=%h want 0/01", bus.irq_out, d);
    end
    bus.mie = 1'b1;
    exp_q.push_back(0);
    wait_irq("mie_raise");
    bus.mie = 1'b0;
    tick(1);
    vectors++;
    if (bus.irq_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mie_drop got irq_out=%b want 0", bus.irq_out);
    end
    bus.src_irq[0] = 1'b0;
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    apply_reset();
    cfg_write(2'd2, 32'h08);
    bus.src_irq[3] = 1'b1;
    tick(2);
    cfg_write(2'd1, 32'h08);
    cfg_read(2'd1, d);
    vectors++;
    if (d !== 32'h08) begin
      miscompares++;
      $display("FAIL set_wins got pend=%h want 08", d);
    end
    cfg_write(2'd1, 32'h08);
    cfg_read(2'd1, d);
    vectors++;
    if (d !== 32'h00) begin
      miscompares++;
      $display("FAIL w1c_clear got pend=%h want 00", d);
    end
    bus.src_irq[3] = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    apply_reset();
    cfg_write(2'd0, 32'h04);
    cfg_write(2'd2, 32'h04);
    bus.mie = 1'b1;
    bus.src_irq[2] = 1'b1;
    exp_q.push_back(2);
    tick(1);
    bus.src_irq[2] = 1'b0;
    wait_irq("rstmid_req");
    pulse_ack();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_service got busy=%b want 1", bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.irq_out, bus.irq_id, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL rstmid_async got irq_out=%b id=%0d busy=%b want 0/0/0",
               bus.irq_out, bus.irq_id, bus.busy);
    end
    @(negedge clk) rst = 1'b1;
    tick(1);
    pulse_mret();
    pulse_ack();
    tick(2);
    cfg_read(2'd3, d);
    vectors++;
    if (bus.irq_out !== 1'b0 || bus.busy !== 1'b0 || d !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_stale got irq_out=%b busy=%b claim=%h want 0/0/0",
               bus.irq_out, bus.busy, d);
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level_priority();
    test_enable_withdraw();
    test_mie();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
